serdesphy_pll_cp_ctrl: RTL and testbench

Sequences the PLL charge pump: power-up settle, high-current acquisition, stepped current reduction, then locked tracking with loss-of-lock recovery. Counts UP/DOWN phase-detector activity per measurement window and drives enable/current-select of serdesphy_ana_pll_charge_pump. Sits in the PLL digital wrapper between the phase detector and the charge pump; lock status goes to the PHY top-level control/status logic.

---
 rtl/serdesphy_pll_cp_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_serdesphy_pll_cp_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serdesphy_pll_cp_ctrl.sv
// rtl/serdesphy_pll_cp_ctrl.sv - PLL charge-pump sequencer (settle, acquire, step-down, track)
// Optional macro SERDESPHY_PLL_CP_FORCE_EN adds cp_force/cp_force_val current override.
module serdesphy_pll_cp_ctrl #(
  parameter int         SETTLE_CYCLES = 256,
  parameter int         WIN_CYCLES    = 64,
  parameter int         LOCK_TOL      = 2,
  parameter int         UNLOCK_TOL    = 8,
  parameter int         LOCK_WINDOWS  = 4,
  parameter logic [1:0] FINAL_CURRENT = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_en,
  input  logic       up_pulse,
  input  logic       down_pulse,
`ifdef SERDESPHY_PLL_CP_FORCE_EN
  input  logic       cp_force,
  input  logic [1:0] cp_force_val,
`endif
  output logic       cp_enable,
  output logic [1:0] cp_current,
  output logic       pll_locked,
  output logic       lock_lost,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_ACQUIRE = 3'd2,
    S_TRACK   = 3'd3
  } state_t;

  localparam int CW  = $clog2(WIN_CYCLES + 1);
  localparam int CW1 = CW + 1;
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);
  localparam int GW  = $clog2(LOCK_WINDOWS + 1);

  state_t        st;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] up_cnt;
  logic [CW-1:0] dn_cnt;
  logic [GW-1:0] good_cnt;
  logic [1:0]    cur_step;

  logic [CW-1:0] up_tot;
  logic [CW-1:0] dn_tot;
  logic [CW:0]   diff;
  logic          win_end;
  logic          win_good;
  logic          win_bad;
  logic [GW-1:0] good_next;
  logic          good_reached;
  logic          step_frozen;
  logic [1:0]    step_d;

`ifdef SERDESPHY_PLL_CP_FORCE_EN
  assign step_frozen = cp_force;
`else
  assign step_frozen = 1'b0;
`endif

  // Window totals include the current cycle so evaluation on the last cycle sees every pulse.
  always_comb begin
    up_tot       = up_cnt + CW'(up_pulse);
    dn_tot       = dn_cnt + CW'(down_pulse);
    diff         = (up_tot >= dn_tot) ? ({1'b0, up_tot} - {1'b0, dn_tot})
                                      : ({1'b0, dn_tot} - {1'b0, up_tot});
    win_end      = (win_cnt == CW'(WIN_CYCLES - 1));
    win_good     = (diff <= CW1'(LOCK_TOL));
    win_bad      = (diff >  CW1'(UNLOCK_TOL));
    good_next    = win_good ? (good_cnt + GW'(1)) : '0;
    good_reached = (good_next == GW'(LOCK_WINDOWS));
  end

  always_comb begin
    step_d = cur_step;
    if (!pll_en) begin
      step_d = 2'b11;
    end else if (st == S_ACQUIRE && win_end && good_reached &&
                 cur_step > FINAL_CURRENT && !step_frozen) begin
      step_d = cur_step - 2'd1;
    end else if (st == S_TRACK && win_end && win_bad) begin
      step_d = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
      up_cnt     <= '0;
      dn_cnt     <= '0;
      good_cnt   <= '0;
      cur_step   <= 2'b11;
      cp_enable  <= 1'b0;
      pll_locked <= 1'b0;
      lock_lost  <= 1'b0;
    end else if (!pll_en) begin
      st         <= S_IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
      up_cnt     <= '0;
      dn_cnt     <= '0;
      good_cnt   <= '0;
      cur_step   <= 2'b11;
      cp_enable  <= 1'b0;
      pll_locked <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      cur_step <= step_d;
      case (st)
        S_IDLE: begin
          st         <= S_SETTLE;
          cp_enable  <= 1'b1;
          settle_cnt <= '0;
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            st      <= S_ACQUIRE;
            win_cnt <= '0;
            up_cnt  <= '0;
            dn_cnt  <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        default: begin
          if (win_end) begin
            win_cnt <= '0;
            up_cnt  <= '0;
            dn_cnt  <= '0;
            if (st == S_ACQUIRE) begin
              if (good_reached) begin
                good_cnt <= '0;
                if (cur_step == FINAL_CURRENT) begin
                  st         <= S_TRACK;
                  pll_locked <= 1'b1;
                end
              end else begin
                good_cnt <= good_next;
              end
            end else if (win_bad) begin
              st         <= S_ACQUIRE;
              pll_locked <= 1'b0;
              lock_lost  <= 1'b1;
              good_cnt   <= '0;
            end
          end else begin
            win_cnt <= win_cnt + CW'(1);
            up_cnt  <= up_tot;
            dn_cnt  <= dn_tot;
          end
        end
      endcase
    end
  end

`ifdef SERDESPHY_PLL_CP_FORCE_EN
  logic [1:0] cp_current_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cp_current_q <= 2'b11;
    end else if (!pll_en) begin
      cp_current_q <= 2'b11;
    end else begin
      cp_current_q <= cp_force ? cp_force_val : step_d;
    end
  end

  assign cp_current = cp_current_q;
`else
  assign cp_current = cur_step;
`endif

  assign state = st;

endmodule

// File: tb/tb_serdesphy_pll_cp_ctrl.sv
// tb/tb_serdesphy_pll_cp_ctrl.sv - self-checking bench for serdesphy_pll_cp_ctrl
module tb_serdesphy_pll_cp_ctrl;

  localparam int         SETTLE = 4;
  localparam int         WIN    = 8;
  localparam int         LTOL   = 1;
  localparam int         UTOL   = 3;
  localparam int         LWIN   = 2;
  localparam logic [1:0] FINAL  = 2'b01;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_en     = 1'b0;
  logic       up_pulse   = 1'b0;
  logic       down_pulse = 1'b0;
`ifdef SERDESPHY_PLL_CP_FORCE_EN
  logic       cp_force     = 1'b0;
  logic [1:0] cp_force_val = 2'b00;
`endif
  logic       cp_enable;
  logic [1:0] cp_current;
  logic       pll_locked;
  logic       lock_lost;
  logic [2:0] state;

  always #5 clk = ~clk;

  serdesphy_pll_cp_ctrl #(
    .SETTLE_CYCLES(SETTLE),
    .WIN_CYCLES   (WIN),
    .LOCK_TOL     (LTOL),
    .UNLOCK_TOL   (UTOL),
    .LOCK_WINDOWS (LWIN),
    .FINAL_CURRENT(FINAL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_en      (pll_en),
    .up_pulse    (up_pulse),
    .down_pulse  (down_pulse),
`ifdef SERDESPHY_PLL_CP_FORCE_EN
    .cp_force    (cp_force),
    .cp_force_val(cp_force_val),
`endif
    .cp_enable   (cp_enable),
    .cp_current  (cp_current),
    .pll_locked  (pll_locked),
    .lock_lost   (lock_lost),
    .state       (state)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, elapsed settle time, running window tallies, good-window streak.
  int m_state = 0, m_settle = 0, m_wpos = 0, m_up = 0, m_dn = 0, m_good = 0;
  int m_cur = 3, m_cp = 3, m_en = 0, m_locked = 0, m_lost = 0, m_d = 0;
  bit m_frozen;

  task model_clear();
    m_state = 0; m_settle = 0; m_wpos = 0; m_up = 0; m_dn = 0; m_good = 0;
    m_cur = 3; m_cp = 3; m_en = 0; m_locked = 0; m_lost = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
`ifdef SERDESPHY_PLL_CP_FORCE_EN
    m_frozen = cp_force;
`else
    m_frozen = 1'b0;
`endif
    if (!rst_n || !pll_en) begin
      model_clear();
    end else begin
      if (m_state == 0) begin
        m_state = 1; m_en = 1; m_settle = 0;
      end else if (m_state == 1) begin
        m_settle++;
        if (m_settle == SETTLE) begin
          m_state = 2; m_wpos = 0; m_up = 0; m_dn = 0;
        end
      end else begin
        m_up += int'(up_pulse);
        m_dn += int'(down_pulse);
        m_wpos++;
        if (m_wpos == WIN) begin
          m_d = (m_up > m_dn) ? m_up - m_dn : m_dn - m_up;
          if (m_state == 2) begin
            m_good = (m_d <= LTOL) ? m_good + 1 : 0;
            if (m_good == LWIN) begin
              m_good = 0;
              if (m_cur == int'(FINAL)) begin
                m_state = 3; m_locked = 1;
              end else if (!m_frozen) begin
                m_cur--;
              end
            end
          end else if (m_d > UTOL) begin
            m_state = 2; m_locked = 0; m_lost = 1; m_cur = 3; m_good = 0;
          end
          m_wpos = 0; m_up = 0; m_dn = 0;
        end
      end
`ifdef SERDESPHY_PLL_CP_FORCE_EN
      m_cp = cp_force ? int'(cp_force_val) : m_cur;
`else
      m_cp = m_cur;
`endif
    end
  end

  always @(negedge clk) begin
    check("state",      int'(state),      m_state);
    check("cp_enable",  int'(cp_enable),  m_en);
    check("cp_current", int'(cp_current), m_cp);
    check("pll_locked", int'(pll_locked), m_locked);
    check("lock_lost",  int'(lock_lost),  m_lost);
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    check("lit_reset_state", int'(state), 0);
    check("lit_reset_cur",   int'(cp_current), 3);
    check("lit_reset_en",    int'(cp_enable), 0);

    // Enable sampled at cycle 0; SETTLE at 1, ACQUIRE at 5, steps at 21/37, lock at 53.
    pll_en = 1'b1;
    adv(1);
    check("lit_settle_state", int'(state), 1);
    check("lit_settle_en",    int'(cp_enable), 1);
    adv(4);
    check("lit_acq_state", int'(state), 2);
    check("lit_acq_cur",   int'(cp_current), 3);
    adv(16);
    check("lit_step2", int'(cp_current), 2);
    adv(16);
    check("lit_step1", int'(cp_current), 1);
    adv(16);
    check("lit_track_state",  int'(state), 3);
    check("lit_track_locked", int'(pll_locked), 1);

    // Four UP pulses in one TRACK window exceed the unlock tolerance.
    up_pulse = 1'b1;
    adv(4);
    up_pulse = 1'b0;
    adv(4);
    check("lit_unlock_state",  int'(state), 2);
    check("lit_unlock_locked", int'(pll_locked), 0);
    check("lit_unlock_lost",   int'(lock_lost), 1);
    check("lit_unlock_cur",    int'(cp_current), 3);

    // Alternate good and diff-2 windows: the streak never reaches two.
    for (int i = 0; i < 2; i++) begin
      adv(8);
      check("lit_alt_good_cur", int'(cp_current), 3);
      up_pulse = 1'b1;
      adv(2);
      up_pulse = 1'b0;
      adv(6);
      check("lit_alt_bad_cur",   int'(cp_current), 3);
      check("lit_alt_bad_state", int'(state), 2);
    end

    // Simultaneous UP and DOWN every cycle nets zero and locks again.
    up_pulse   = 1'b1;
    down_pulse = 1'b1;
    adv(16);
    check("lit_both_step2", int'(cp_current), 2);
    adv(16);
    check("lit_both_step1", int'(cp_current), 1);
    adv(16);
    check("lit_both_track", int'(state), 3);
    check("lit_both_lost",  int'(lock_lost), 1);
    pll_en = 1'b0;
    adv(1);
    check("lit_dis_state", int'(state), 0);
    check("lit_dis_en",    int'(cp_enable), 0);
    check("lit_dis_lost",  int'(lock_lost), 0);
    check("lit_dis_cur",   int'(cp_current), 3);
    up_pulse   = 1'b0;
    down_pulse = 1'b0;

    // Asynchronous reset in the middle of an ACQUIRE window at current 2.
    pll_en = 1'b1;
    adv(5);
    adv(16);
    check("lit_pre_rst_cur", int'(cp_current), 2);
    adv(3);
    #1 rst_n = 1'b0;
    #1;
    check("lit_async_state",  int'(state), 0);
    check("lit_async_cur",    int'(cp_current), 3);
    check("lit_async_en",     int'(cp_enable), 0);
    check("lit_async_locked", int'(pll_locked), 0);
    adv(2);
    rst_n = 1'b1;

`ifdef SERDESPHY_PLL_CP_FORCE_EN
    adv(5);
    check("lit_force_pre_state", int'(state), 2);
    cp_force     = 1'b1;
    cp_force_val = 2'b00;
    adv(1);
    check("lit_force_cur",   int'(cp_current), 0);
    check("lit_force_state", int'(state), 2);
    adv(16);
    check("lit_force_hold", int'(cp_current), 0);
    cp_force = 1'b0;
    adv(1);
    check("lit_force_release", int'(cp_current), 3);
`endif

    adv(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
